csp_sync_bridge: RTL

Clocked receive stage that sits directly downstream of the 1-bit conditional buffer in the router datapath. It consumes the buffer's 4-phase bundled-data output: the data bit and the route-request bit travel together as one `WIDTH`-bit token. Each token is synchronised into the `clk` domain, acknowledged, and queued in a small FIFO. The FIFO presents tokens to clocked router logic through a valid/ready interface.

---
 rtl/router_pkg.sv | 12 +
 rtl/csp_sync.sv | 25 ++
 rtl/csp_sync_bridge.sv | 103 ++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: handshake FSM encodings, token bit layout and
// the default token width.
package router_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACKED = 1'b1;

  localparam int TOK_DATA = 0;
  localparam int TOK_REQ  = 1;
  localparam int TOKEN_W  = 2;

endpackage

// File: rtl/csp_sync.sv
// Multi-flop synchronizer for a single asynchronous level into the clk domain.
// Async active-low reset clears every stage.
module csp_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_p;

  // Stage boundary: the shift chain, oldest sample at the MSB
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/csp_sync_bridge.sv
// 4-phase bundled-data receiver: synchronises in_req, acknowledges each token
// once, and queues tokens in a small FIFO drained through valid/ready.
module csp_sync_bridge
  import router_pkg::*;
#(
  parameter int WIDTH       = TOKEN_W,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_req,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ack,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                 req_s;
  logic [0:0]           state;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [WIDTH-1:0]     mem [DEPTH];
  logic                 full;
  logic                 push;
  logic                 pop;

  // Explicit wrap so non-power-of-two depths index only valid entries
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  csp_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_req),
    .q     (req_s)
  );

  // No bypass: a pop in this cycle does not make room for a push in this cycle
  assign full      = (count == CNT_W'(DEPTH));
  assign push      = (state == ST_IDLE) && req_s && !full;
  assign pop       = out_valid && out_ready;
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  // Stage boundary: handshake FSM, ack is the registered state of the token
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      in_ack <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (push) begin
            state  <= ST_ACKED;
            in_ack <= 1'b1;
          end
        end
        default: begin
          if (!req_s) begin
            state  <= ST_IDLE;
            in_ack <= 1'b0;
          end
        end
      endcase
    end
  end

  // Stage boundary: FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Stage boundary: token storage; in_data is bundled, so sampled unsynchronised
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule
